// File: rtl/psum_accum_quant.sv
`timescale 1ns/1ps
// Accumulates NUM_PASS partial sums per output pixel on top of a signed bias, then
// rounds, applies ReLU and saturates to OUT_W bits into a small FWFT output FIFO.
module psum_accum_quant #(
    parameter int PSUM_W     = 14,
    parameter int ACC_W      = 20,
    parameter int OUT_W      = 8,
    parameter int NUM_PASS   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [ACC_W-1:0]  cfg_bias,
    input  logic [3:0]        cfg_shift,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [OUT_W-1:0]  ofmap_out,
    output logic              ofmap_valid,
    input  logic              ofmap_ready,
    output logic              ovf_sticky
);

    localparam int SUM_W  = ACC_W + 2;
    localparam int RND_W  = SUM_W + 1;
    localparam int CNT_W  = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_PASS = CNT_W'(NUM_PASS - 1);
    localparam logic [FCNT_W:0]   DEPTH_L   = (FCNT_W + 1)'(FIFO_DEPTH);

    logic [CNT_W-1:0]        r_pass_cnt;
    logic signed [SUM_W-1:0] r_acc;
    logic [OUT_W-1:0]        r_q_data;
    logic                    r_q_valid;
    logic                    r_ovf;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [FCNT_W-1:0]       r_fifo_count;
    logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];

    logic                    w_beat;
    logic                    w_first;
    logic                    w_last;
    logic signed [SUM_W-1:0] w_bias_ext;
    logic signed [SUM_W-1:0] w_psum_ext;
    logic signed [SUM_W-1:0] w_base;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [RND_W-1:0] w_sum_ext;
    logic signed [RND_W-1:0] w_half;
    logic signed [RND_W-1:0] w_biased;
    logic signed [RND_W-1:0] w_rounded;
    logic                    w_neg;
    logic                    w_sat;
    logic [OUT_W-1:0]        w_q_next;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_nonempty;
    logic [FCNT_W:0]         w_occupancy;

    assign w_first    = (r_pass_cnt == '0);
    assign w_last     = (r_pass_cnt == LAST_PASS);
    assign w_bias_ext = {{(SUM_W - ACC_W){cfg_bias[ACC_W-1]}}, cfg_bias};
    assign w_psum_ext = {{(SUM_W - PSUM_W){1'b0}}, psum_in};
    assign w_base     = w_first ? w_bias_ext : r_acc;
    assign w_sum      = w_base + w_psum_ext;

    // One extra bit so adding the rounding half can never wrap.
    assign w_sum_ext  = {w_sum[SUM_W-1], w_sum};
    assign w_half     = (cfg_shift == 4'd0) ? '0 : (RND_W'(1) << (cfg_shift - 4'd1));
    assign w_biased   = w_sum_ext + w_half;
    assign w_rounded  = w_biased >>> cfg_shift;

    assign w_neg    = w_rounded[RND_W-1];
    assign w_sat    = !w_neg && (|w_rounded[RND_W-2:OUT_W]);
    assign w_q_next = w_neg ? '0 : (w_sat ? '1 : w_rounded[OUT_W-1:0]);

    // Results in the quant stage count against FIFO space so nothing is ever dropped.
    assign w_occupancy     = {1'b0, r_fifo_count} + {{FCNT_W{1'b0}}, r_q_valid};
    assign psum_ready      = (w_occupancy < DEPTH_L);
    assign w_beat          = psum_valid && psum_ready;
    assign w_fifo_nonempty = (r_fifo_count != '0);
    assign w_push          = r_q_valid;
    assign w_pop           = w_fifo_nonempty && ofmap_ready;

    assign ofmap_valid = w_fifo_nonempty;
    assign ofmap_out   = w_fifo_nonempty ? r_mem[r_rd_ptr] : '0;
    assign ovf_sticky  = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt   <= '0;
            r_acc        <= '0;
            r_q_data     <= '0;
            r_q_valid    <= 1'b0;
            r_ovf        <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else if (clr) begin
            r_pass_cnt   <= '0;
            r_acc        <= '0;
            r_q_data     <= '0;
            r_q_valid    <= 1'b0;
            r_ovf        <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_beat) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_pass_cnt <= '0;
                    r_q_data   <= w_q_next;
                    if (w_sat) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end
            end
            r_q_valid <= w_beat && w_last;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + FCNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_fifo_count <= r_fifo_count - FCNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_q_data;
        end
    end

endmodule

// File: tb/tb_psum_accum_quant.sv
`timescale 1ns/1ps
// Self-checking bench for psum_accum_quant: directed scenarios plus a randomized
// run scored against a queue-based arithmetic reference model.
module tb_psum_accum_quant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [19:0] cfg_bias;
    logic [3:0]  cfg_shift;
    logic [13:0] psum_in;
    logic        psum_valid;
    logic        psum_ready;
    logic [7:0]  ofmap_out;
    logic        ofmap_valid;
    logic        ofmap_ready;
    logic        ovf_sticky;

    int n_cmp  = 0;
    int n_fail = 0;

    psum_accum_quant #(
        .PSUM_W(14), .ACC_W(20), .OUT_W(8), .NUM_PASS(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
        .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .ofmap_out(ofmap_out), .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one full pixel (three beats), waiting a bounded time for psum_ready.
    task automatic send_pixel(input int a, input int b, input int c,
                              input int bias, input int shift);
        int vals [3];
        vals[0] = a; vals[1] = b; vals[2] = c;
        cfg_bias  = 20'(bias);
        cfg_shift = 4'(shift);
        for (int i = 0; i < 3; i++) begin
            int guard;
            guard = 0;
            psum_valid = 1'b1;
            psum_in    = 14'(vals[i]);
            while (!psum_ready && guard < 50) begin
                cycle();
                guard++;
            end
            if (guard >= 50) begin
                n_cmp++; n_fail++;
                $display("FAIL send_timeout: psum_ready stayed 0 for %0d cycles, required 1", guard);
            end
            cycle();
        end
        psum_valid = 1'b0;
    endtask

    // Rounded, arithmetically shifted sum before clamping.
    function automatic longint round_shift(input longint sum, input int sh);
        if (sh == 0) return sum;
        return (sum + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; cfg_bias = '0; cfg_shift = '0;
        psum_in = '0; psum_valid = 1'b0; ofmap_ready = 1'b1;
        #3;
        n_cmp++;
        if (ofmap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", ofmap_valid); end
        n_cmp++;
        if (ofmap_out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d, required 0", ofmap_out); end
        n_cmp++;
        if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf_sticky); end
        #20 rst_n = 1'b1;
        cycle();
        n_cmp++;
        if (psum_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", psum_ready); end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_basic();
        ofmap_ready = 1'b1;
        send_pixel(10, 20, 30, 0, 0);
        n_cmp++;
        if (ofmap_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", ofmap_valid); end
        cycle();
        n_cmp++;
        if (ofmap_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, required 1", ofmap_valid); end
        n_cmp++;
        if (ofmap_out !== 8'd60) begin n_fail++; $display("FAIL basic_out: got %0d, required 60", ofmap_out); end
        n_cmp++;
        if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b, required 0", ovf_sticky); end
        cycle();
        n_cmp++;
        if (ofmap_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got valid %b, required 0", ofmap_valid); end
        $display("test_basic: out=60 expected, compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_relu_round();
        ofmap_ready = 1'b1;
        send_pixel(10, 20, 30, -100, 0);
        cycle();
        n_cmp++;
        if (ofmap_valid !== 1'b1 || ofmap_out !== 8'd0) begin
            n_fail++; $display("FAIL relu_out: got valid %b out %0d, required valid 1 out 0", ofmap_valid, ofmap_out);
        end
        n_cmp++;
        if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL relu_ovf: got %b, required 0", ovf_sticky); end
        cycle();
        send_pixel(100, 100, 100, 5, 4);
        cycle();
        n_cmp++;
        if (ofmap_valid !== 1'b1 || ofmap_out !== 8'd19) begin
            n_fail++; $display("FAIL round_out: got valid %b out %0d, required valid 1 out 19", ofmap_valid, ofmap_out);
        end
        cycle();
        $display("test_relu_round: outputs 0 and 19 expected, compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_saturate_clr();
        ofmap_ready = 1'b1;
        send_pixel(16383, 16383, 16383, 0, 2);
        cycle();
        n_cmp++;
        if (ofmap_valid !== 1'b1 || ofmap_out !== 8'd255) begin
            n_fail++; $display("FAIL sat_out: got valid %b out %0d, required valid 1 out 255", ofmap_valid, ofmap_out);
        end
        n_cmp++;
        if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b, required 1", ovf_sticky); end
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        n_cmp++;
        if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b, required 0", ovf_sticky); end
        $display("test_saturate_clr: 255 with ovf then clr, compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_back_to_back();
        int idx;
        int n_out;
        idx = 0; n_out = 0;
        cfg_bias = '0; cfg_shift = '0;
        ofmap_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            psum_valid = (idx < 18);
            psum_in    = (idx % 3 == 0) ? 14'(idx / 3 + 1) : 14'd0;
            if (psum_valid && psum_ready) idx++;
            cycle();
            if (ofmap_valid) begin
                n_cmp++;
                if (ofmap_out !== 8'd1) begin n_fail++; $display("FAIL stall_hold: got %0d, required 1", ofmap_out); end
            end
        end
        n_cmp++;
        if (idx !== 12) begin n_fail++; $display("FAIL stall_beats: accepted %0d beats, required 12", idx); end
        n_cmp++;
        if (psum_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b, required 0", psum_ready); end
        ofmap_ready = 1'b1;
        for (int c = 0; c < 60 && (n_out < 6 || idx < 18); c++) begin
            psum_valid = (idx < 18);
            psum_in    = (idx % 3 == 0) ? 14'(idx / 3 + 1) : 14'd0;
            if (psum_valid && psum_ready) idx++;
            if (ofmap_valid && ofmap_ready) begin
                n_cmp++;
                if (ofmap_out !== 8'(n_out + 1)) begin
                    n_fail++; $display("FAIL order_out%0d: got %0d, required %0d", n_out, ofmap_out, n_out + 1);
                end
                $display("back_to_back pop %0d: out=%0d", n_out, ofmap_out);
                n_out++;
            end
            cycle();
        end
        psum_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ofmap_valid) n_out++;
            cycle();
        end
        n_cmp++;
        if (n_out !== 6) begin n_fail++; $display("FAIL order_count: got %0d outputs, required 6", n_out); end
    endtask

    task automatic test_clr_mid();
        int n_out;
        n_out = 0;
        ofmap_ready = 1'b1;
        cfg_bias = '0; cfg_shift = '0;
        psum_valid = 1'b1; psum_in = 14'd50;
        cycle();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0; psum_valid = 1'b0;
        n_cmp++;
        if (ofmap_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b, required 0", ofmap_valid); end
        send_pixel(1, 2, 3, 0, 0);
        for (int c = 0; c < 6; c++) begin
            if (ofmap_valid && ofmap_ready) begin
                n_cmp++;
                if (ofmap_out !== 8'd6) begin n_fail++; $display("FAIL clr_out: got %0d, required 6", ofmap_out); end
                n_out++;
            end
            cycle();
        end
        n_cmp++;
        if (n_out !== 1) begin n_fail++; $display("FAIL clr_count: got %0d outputs, required 1", n_out); end
        $display("test_clr_mid: outputs=%0d", n_out);
    endtask

    task automatic test_async_reset();
        ofmap_ready = 1'b0;
        send_pixel(1, 1, 1, 0, 0);
        send_pixel(2, 2, 2, 0, 0);
        cycle();
        psum_valid = 1'b1; psum_in = 14'd5;
        cycle();
        psum_valid = 1'b0;
        n_cmp++;
        if (ofmap_valid !== 1'b1 || ofmap_out !== 8'd3) begin
            n_fail++; $display("FAIL prereset_head: got valid %b out %0d, required valid 1 out 3", ofmap_valid, ofmap_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ofmap_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b, required 0", ofmap_valid); end
        n_cmp++;
        if (ofmap_out !== 8'd0) begin n_fail++; $display("FAIL async_out: got %0d, required 0", ofmap_out); end
        #4;
        cycle();
        #3 rst_n = 1'b1;
        cycle();
        ofmap_ready = 1'b1;
        send_pixel(7, 8, 9, 0, 0);
        cycle();
        n_cmp++;
        if (ofmap_valid !== 1'b1 || ofmap_out !== 8'd24) begin
            n_fail++; $display("FAIL postreset_out: got valid %b out %0d, required valid 1 out 24", ofmap_valid, ofmap_out);
        end
        cycle();
        $display("test_async_reset: post-reset out=24 expected");
    endtask

    task automatic test_random();
        longint exp_q [$];
        longint m_acc;
        longint r;
        int     m_cnt;
        int     rb;
        bit     m_ovf;
        bit     do_beat;
        bit     do_pop;
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            psum_valid  = ($urandom_range(0, 9) < 7);
            psum_in     = ($urandom_range(0, 1) == 1) ? 14'($urandom) : 14'($urandom_range(0, 255));
            rb          = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1048575)) - 524288
                                                      : int'($urandom_range(0, 4000)) - 2000;
            cfg_bias    = 20'(rb);
            cfg_shift   = 4'($urandom_range(0, 15));
            ofmap_ready = ($urandom_range(0, 9) < 6);
            do_beat = psum_valid && psum_ready;
            do_pop  = ofmap_valid && ofmap_ready;
            if (do_pop) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious: popped %0d with no result expected", ofmap_out);
                end else begin
                    r = exp_q.pop_front();
                    if (ofmap_out !== 8'(r)) begin
                        n_fail++; $display("FAIL rand_out: cycle %0d got %0d, required %0d", c, ofmap_out, r);
                    end
                end
            end
            if (do_beat) begin
                if (m_cnt == 0) m_acc = longint'(rb) + longint'(psum_in);
                else            m_acc = m_acc + longint'(psum_in);
                m_cnt++;
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    r = round_shift(m_acc, int'(cfg_shift));
                    if (r < 0) r = 0;
                    else if (r > 255) begin r = 255; m_ovf = 1'b1; end
                    exp_q.push_back(r);
                end
            end
            cycle();
            n_cmp++;
            if (psum_ready !== (exp_q.size() < 4)) begin
                n_fail++; $display("FAIL rand_ready: cycle %0d got %b with %0d pending", c, psum_ready, exp_q.size());
            end
            n_cmp++;
            if (ovf_sticky !== m_ovf) begin
                n_fail++; $display("FAIL rand_ovf: cycle %0d got %b, required %b", c, ovf_sticky, m_ovf);
            end
        end
        psum_valid  = 1'b0;
        ofmap_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (ofmap_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL drain_spurious: popped %0d", ofmap_out);
                end else begin
                    r = exp_q.pop_front();
                    if (ofmap_out !== 8'(r)) begin
                        n_fail++; $display("FAIL drain_out: got %0d, required %0d", ofmap_out, r);
                    end
                end
            end
            cycle();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left: %0d results never appeared", exp_q.size()); end
        $display("test_random done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu_round();
        test_saturate_clr();
        test_back_to_back();
        test_clr_mid();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
